// File: rtl/rwl_ctrl_pkg.sv
// rwl_ctrl_pkg: shared state encoding and default geometry/timing for the read-wordline sequencer.
package rwl_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, PRECH, WL_ON, SENSE, DONE} rwl_state_t;
   localparam int RWL_ROWS      = 256;
   localparam int RWL_ADDR_W    = 8;
   localparam int RWL_PRE_CYC   = 2;
   localparam int RWL_WL_CYC    = 3;
   localparam int RWL_SENSE_CYC = 1;
   localparam int RWL_CNT_W     = 4;
endpackage

// File: rtl/rwl_onehot_dec.sv
// rwl_onehot_dec: ADDR_W-to-ROWS one-hot decoder; all-zero when disabled or address out of range.
module rwl_onehot_dec
   import rwl_ctrl_pkg::*;
#(
   parameter int ROWS   = RWL_ROWS,
   parameter int ADDR_W = RWL_ADDR_W
) (
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [ROWS-1:0]   oh
);
   for (genvar i = 0; i < ROWS; i++) begin : g_row
      assign oh[i] = en && (addr == ADDR_W'(i));
   end
endmodule

// File: rtl/rwl_pulse_ctrl.sv
// rwl_pulse_ctrl: per-request precharge, one-hot wordline pulse and sense-enable sequencer
// with REQ/ACK handshake; every output is a flop.
module rwl_pulse_ctrl
   import rwl_ctrl_pkg::*;
#(
   parameter int ROWS      = RWL_ROWS,
   parameter int ADDR_W    = RWL_ADDR_W,
   parameter int PRE_CYC   = RWL_PRE_CYC,
   parameter int WL_CYC    = RWL_WL_CYC,
   parameter int SENSE_CYC = RWL_SENSE_CYC,
   parameter int CNT_W     = RWL_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic [ROWS-1:0]   rwl,
   output logic              pre,
   output logic              sae,
   output logic              busy,
   output logic              ack,
   output logic              err
);
   localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);
   localparam logic [CNT_W-1:0] WL_LD    = CNT_W'(WL_CYC - 1);
   localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(SENSE_CYC - 1);
   rwl_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;
   logic [ROWS-1:0]   dec;
   rwl_onehot_dec #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_dec (
      .en   (!err_q),
      .addr (addr_q),
      .oh   (dec)
   );
   // Each phase transition clears the previous phase's enable on the same edge it raises the next,
   // so PRE/RWL/SAE never overlap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         addr_q <= '0;
         err_q  <= 1'b0;
         rwl    <= '0;
         pre    <= 1'b0;
         sae    <= 1'b0;
         busy   <= 1'b0;
         ack    <= 1'b0;
         err    <= 1'b0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: if (req) begin
               addr_q <= addr;
               err_q  <= int'(addr) >= ROWS;
               busy   <= 1'b1;
               pre    <= 1'b1;
               cnt    <= PRE_LD;
               state  <= PRECH;
            end
            PRECH: if (cnt == '0) begin
               pre   <= 1'b0;
               rwl   <= dec;
               cnt   <= WL_LD;
               state <= WL_ON;
            end else cnt <= cnt - 1'b1;
            WL_ON: if (cnt == '0) begin
               rwl   <= '0;
               sae   <= 1'b1;
               cnt   <= SENSE_LD;
               state <= SENSE;
            end else cnt <= cnt - 1'b1;
            SENSE: if (cnt == '0) begin
               sae   <= 1'b0;
               ack   <= 1'b1;
               err   <= err_q;
               state <= DONE;
            end else cnt <= cnt - 1'b1;
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               rwl   <= '0;
               pre   <= 1'b0;
               sae   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
